fwd_hazard_sb: RTL and testbench
================================

# fwd_hazard_sb

Parametrised forwarding and hazard unit for the integer/FP RISC-V pipeline. It generates per-operand forward selects for the EX stage, detects load-use hazards, and keeps a scoreboard of destination registers owned by in-flight long-latency operations (divider, FPU). It also produces the ID-stage stall, an issue-ready flag for the long unit, and saturating stall counters. It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the long-latency unit's issue and writeback ports.

## Interface

Parameters:
- `WIDTH_SOURCE`, 5: register index width.
- `NUM_SRC`, 3: source operands per instruction (rs1, rs2, rs3).
- `MAX_LONG`, 4: maximum outstanding long-latency operations (1..15).
- `CNT_W`, 16: stall-counter width.

Ports (clock and reset first):
- `CLK` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: ID stage holds a valid instruction.
- `id_rs` in NUM_SRC*WIDTH_SOURCE: ID source indices; operand i is at [i*WIDTH_SOURCE +: WIDTH_SOURCE].
- `id_rs_use` in NUM_SRC: operand i is read.
- `id_rs_fp` in NUM_SRC: operand i is in the FP file.
- `ID_EX_valid`, `ID_EX_Mem_Rd`, `ID_EX_Reg_Wr`, `ID_EX_rd_fp` in 1 each: EX instruction is valid, is a load, writes a register, and targets the FP file.
- `ID_EX_rd` in WIDTH_SOURCE: EX destination.
- `ID_EX_rs` in NUM_SRC*WIDTH_SOURCE; `ID_EX_rs_fp` in NUM_SRC: EX source indices and register classes.
- `EX_MEM_Reg_Wr`, `EX_MEM_rd_fp` in 1; `EX_MEM_rd` in WIDTH_SOURCE.
- `MEM_WB_Reg_Wr`, `MEM_WB_rd_fp` in 1; `MEM_WB_rd` in WIDTH_SOURCE.
- `long_issue`, `long_issue_fp` in 1; `long_issue_rd` in WIDTH_SOURCE: long op accepted this cycle.
- `long_wb_valid`, `long_wb_fp` in 1; `long_wb_rd` in WIDTH_SOURCE: long op writes back this cycle.
- `flush` in 1: pipeline flush.
- `Forward` out 2*NUM_SRC: per-operand select; 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 long writeback bus.
- `id_stall` out 1: hold PC and IF/ID, bubble ID/EX.
- `stall_cause` out 2: 00 none, 01 load-use, 10 scoreboard, 11 both.
- `long_ready` out 1: long unit may issue.
- `sb_err` out 1: sticky protocol error.
- `stall_cnt`, `sb_stall_cnt` out CNT_W: saturating counters.

## Operation

- **Register-class match.** A match requires equal index and equal class bit. Integer x0 never matches. FP f0 is a real register and does match.
- **Forwarding (combinational, per operand i).** Priority order:
  1. EX_MEM_Reg_Wr and match with EX_MEM_rd: 10.
  2. Else MEM_WB_Reg_Wr and match with MEM_WB_rd: 01.
  3. Else long_wb_valid and match with long_wb_rd: 11.
  4. Else 00.
- **Load-use hazard.** Asserted when id_valid, ID_EX_valid, ID_EX_Mem_Rd and ID_EX_Reg_Wr are all set, and some used operand matches ID_EX_rd.
- **Scoreboard.** Two pending bitmaps of 2^WIDTH_SOURCE bits each, one integer and one FP.
  - Scoreboard hazard: id_valid and any used operand's bit is set.
  - Writes to integer x0 never set a bit.
- **Outputs.** id_stall is the OR of the two hazards. stall_cause reports which hazards are active. flush forces id_stall and stall_cause to 0 in that cycle.
- **Scoreboard update at the clock edge.**
  - long_issue sets the bit; long_wb_valid clears it.
  - Same register, both events in one cycle: set wins.
  - A clear is seen only from the next cycle. A reader in the writeback cycle stalls one cycle; forward select 11 serves EX-stage readers only.
- **Pending counter.** 0..MAX_LONG.
  - Incremented by long_issue, decremented by long_wb_valid; both in one cycle leaves it unchanged.
  - long_ready = (count < MAX_LONG).
- **Protocol errors (set sb_err, sticky until reset).**
  - long_issue while count == MAX_LONG (without a simultaneous writeback): the issue is ignored.
  - long_wb_valid whose bit is clear, or while count == 0: the clear and the decrement are ignored.
- **Counters.**
  - stall_cnt increments every cycle id_stall = 1.
  - sb_stall_cnt increments every cycle stall_cause[1] = 1.
  - Both saturate at all-ones.
- **flush.** Does not clear the scoreboard or the counter, because in-flight long ops still write back.

## Timing

- Forward, id_stall, stall_cause and long_ready are combinational from inputs and current state: zero latency.
- Scoreboard, pending count, sb_err and counters update on the CLK rising edge and are visible one cycle later.
- Reset (asynchronous, any time including mid-operation) clears:
  - both bitmaps and the pending count;
  - sb_err and both counters.
- After reset: long_ready = 1, id_stall = 0, Forward = 0.
- A load-use stall lasts exactly one cycle; the load then moves to MEM and is served by select 10.
- A scoreboard stall lasts until the cycle after the matching writeback.

## Test plan

- **Forward priority.** EX_MEM_rd = MEM_WB_rd = long_wb_rd = 5, all writing, operand rs1 = 5 integer. Required: Forward[1:0] = 10. Drop EX_MEM_Reg_Wr: 01. Then drop MEM_WB_Reg_Wr: 11.
- **Class and x0 rules.**
  - EX_MEM_rd = 0 integer, rs1 = 0: Forward 00.
  - EX_MEM_rd = 0 FP, rs1 = f0: Forward 10.
  - EX_MEM_rd = 3 FP, rs1 = x3 integer: Forward 00.
- **Load-use.** Load to x7 in EX, ID uses rs2 = x7. Required: id_stall = 1 and stall_cause = 01 for one cycle, stall_cnt = 1. Next cycle Forward[3:2] = 10.
- **Scoreboard.**
  - Issue a long op to f9, then hold ID reading f9 for 6 cycles: stall_cause = 10 throughout.
  - long_wb of f9 in cycle 6: the stall drops in cycle 7. sb_stall_cnt = 7.
  - Same-cycle issue and writeback of f9: the bit stays set.
- **Capacity and errors.**
  - Issue 4 ops: long_ready = 0. A 5th issue sets sb_err and the count stays 4.
  - Reset: count 0, long_ready = 1, sb_err = 0.
  - long_wb of an unset register sets sb_err.
- **Saturation and flush.**
  - With CNT_W = 4, 20 stall cycles give stall_cnt = 15.
  - flush during a scoreboard stall gives id_stall = 0 and the bitmap is preserved.

Source files
------------

// File: rtl/fwd_hazard_sb.sv
// fwd_hazard_sb: EX operand forwarding, load-use detection and a scoreboard
// of registers owned by in-flight long-latency ops (divider, FPU).
//
// Ports:
//   CLK, rst_n          clock (rising edge), async active-low reset
//   id_*                ID-stage source indices, use and class bits
//   ID_EX_*             EX-stage instruction (load/dest/sources)
//   EX_MEM_*, MEM_WB_*  later-stage destinations for forwarding
//   long_issue*         long op accepted this cycle
//   long_wb*            long op writeback this cycle
//   flush               pipeline flush, masks the stall
//   Forward             2 bits per operand: 00 RF, 10 EX/MEM,
//                       01 MEM/WB, 11 long writeback bus
//   id_stall            hold PC and IF/ID, bubble ID/EX
//   stall_cause         {scoreboard, load-use}
//   long_ready          long unit may issue
//   sb_err              sticky protocol error
//   stall_cnt           saturating count of id_stall cycles
//   sb_stall_cnt        saturating count of scoreboard stall cycles
module fwd_hazard_sb #(
    parameter int WIDTH_SOURCE = 5,
    parameter int NUM_SRC      = 3,
    parameter int MAX_LONG     = 4,
    parameter int CNT_W        = 16
) (
    input  logic                            CLK,
    input  logic                            rst_n,
    input  logic                            id_valid,
    input  logic [NUM_SRC*WIDTH_SOURCE-1:0] id_rs,
    input  logic [NUM_SRC-1:0]              id_rs_use,
    input  logic [NUM_SRC-1:0]              id_rs_fp,
    input  logic                            ID_EX_valid,
    input  logic                            ID_EX_Mem_Rd,
    input  logic                            ID_EX_Reg_Wr,
    input  logic                            ID_EX_rd_fp,
    input  logic [WIDTH_SOURCE-1:0]         ID_EX_rd,
    input  logic [NUM_SRC*WIDTH_SOURCE-1:0] ID_EX_rs,
    input  logic [NUM_SRC-1:0]              ID_EX_rs_fp,
    input  logic                            EX_MEM_Reg_Wr,
    input  logic                            EX_MEM_rd_fp,
    input  logic [WIDTH_SOURCE-1:0]         EX_MEM_rd,
    input  logic                            MEM_WB_Reg_Wr,
    input  logic                            MEM_WB_rd_fp,
    input  logic [WIDTH_SOURCE-1:0]         MEM_WB_rd,
    input  logic                            long_issue,
    input  logic                            long_issue_fp,
    input  logic [WIDTH_SOURCE-1:0]         long_issue_rd,
    input  logic                            long_wb_valid,
    input  logic                            long_wb_fp,
    input  logic [WIDTH_SOURCE-1:0]         long_wb_rd,
    input  logic                            flush,
    output logic [2*NUM_SRC-1:0]            Forward,
    output logic                            id_stall,
    output logic [1:0]                      stall_cause,
    output logic                            long_ready,
    output logic                            sb_err,
    output logic [CNT_W-1:0]                stall_cnt,
    output logic [CNT_W-1:0]                sb_stall_cnt
);

    localparam int NREG = 1 << WIDTH_SOURCE;
    localparam int PCW  = $clog2(MAX_LONG + 1);
    localparam logic [PCW-1:0] P_MAX = PCW'(MAX_LONG);

    // Same index and same class; integer x0 is hardwired and never matches.
    function automatic logic f_match(
        input logic [WIDTH_SOURCE-1:0] a,
        input logic                    a_fp,
        input logic [WIDTH_SOURCE-1:0] b,
        input logic                    b_fp
    );
        return (a == b) && (a_fp == b_fp) && (a_fp || (a != '0));
    endfunction

    logic [NREG-1:0]  r_sb_int;
    logic [NREG-1:0]  r_sb_fp;
    logic [PCW-1:0]   r_cnt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_sb_stall_cnt;

    logic [NREG-1:0]  w_sb_int_n;
    logic [NREG-1:0]  w_sb_fp_n;
    logic [NUM_SRC-1:0] w_lu_op;
    logic [NUM_SRC-1:0] w_sb_op;
    logic             w_lu;
    logic             w_sbh;
    logic             w_wb_bit;
    logic             w_wb_ok;
    logic             w_iss_ok;
    logic             w_iss_x0;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_op
        logic [WIDTH_SOURCE-1:0] w_ex_rs;
        logic [WIDTH_SOURCE-1:0] w_id_rs;
        logic                    w_em;
        logic                    w_mw;
        logic                    w_lw;
        logic [1:0]              w_sel;

        assign w_ex_rs = ID_EX_rs[gi*WIDTH_SOURCE +: WIDTH_SOURCE];
        assign w_id_rs = id_rs[gi*WIDTH_SOURCE +: WIDTH_SOURCE];

        // Hits are masked down the priority chain so exactly one is live.
        assign w_em = EX_MEM_Reg_Wr &&
            f_match(w_ex_rs, ID_EX_rs_fp[gi], EX_MEM_rd, EX_MEM_rd_fp);
        assign w_mw = !w_em && MEM_WB_Reg_Wr &&
            f_match(w_ex_rs, ID_EX_rs_fp[gi], MEM_WB_rd, MEM_WB_rd_fp);
        assign w_lw = !w_em && !w_mw && long_wb_valid &&
            f_match(w_ex_rs, ID_EX_rs_fp[gi], long_wb_rd, long_wb_fp);

        always_comb begin
            w_sel = 2'b00;
            unique case (1'b1)
                w_em:    w_sel = 2'b10;
                w_mw:    w_sel = 2'b01;
                w_lw:    w_sel = 2'b11;
                default: w_sel = 2'b00;
            endcase
        end

        assign Forward[2*gi +: 2] = w_sel;

        assign w_lu_op[gi] = id_rs_use[gi] &&
            f_match(w_id_rs, id_rs_fp[gi], ID_EX_rd, ID_EX_rd_fp);

        assign w_sb_op[gi] = id_rs_use[gi] &&
            (id_rs_fp[gi] ? r_sb_fp[w_id_rs] : r_sb_int[w_id_rs]);
    end

    assign w_lu = id_valid && ID_EX_valid && ID_EX_Mem_Rd &&
                  ID_EX_Reg_Wr && (|w_lu_op);
    assign w_sbh = id_valid && (|w_sb_op);

    assign id_stall    = !flush && (w_lu || w_sbh);
    assign stall_cause = flush ? 2'b00 : {w_sbh, w_lu};
    assign long_ready  = (r_cnt < P_MAX);

    // A writeback is only honoured for an owned register with ops pending;
    // a full unit may still issue when a writeback frees a slot this cycle.
    assign w_wb_bit = long_wb_fp ? r_sb_fp[long_wb_rd]
                                 : r_sb_int[long_wb_rd];
    assign w_wb_ok  = long_wb_valid && w_wb_bit && (r_cnt != '0);
    assign w_iss_ok = long_issue && ((r_cnt != P_MAX) || w_wb_ok);
    assign w_iss_x0 = !long_issue_fp && (long_issue_rd == '0);

    // Clear first, then set, so a same-register issue wins.
    always_comb begin
        w_sb_int_n = r_sb_int;
        w_sb_fp_n  = r_sb_fp;
        if (w_wb_ok) begin
            if (long_wb_fp) w_sb_fp_n[long_wb_rd] = 1'b0;
            else            w_sb_int_n[long_wb_rd] = 1'b0;
        end
        if (w_iss_ok && !w_iss_x0) begin
            if (long_issue_fp) w_sb_fp_n[long_issue_rd] = 1'b1;
            else               w_sb_int_n[long_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_int <= '0;
            r_sb_fp  <= '0;
        end else begin
            r_sb_int <= w_sb_int_n;
            r_sb_fp  <= w_sb_fp_n;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_iss_ok && !w_wb_ok) begin
            r_cnt <= r_cnt + PCW'(1);
        end else if (w_wb_ok && !w_iss_ok) begin
            r_cnt <= r_cnt - PCW'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((long_issue && !w_iss_ok) ||
                     (long_wb_valid && !w_wb_ok)) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt    <= '0;
            r_sb_stall_cnt <= '0;
        end else begin
            if (id_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (stall_cause[1] && (r_sb_stall_cnt != '1))
                r_sb_stall_cnt <= r_sb_stall_cnt + CNT_W'(1);
        end
    end

    assign sb_err       = r_err;
    assign stall_cnt    = r_stall_cnt;
    assign sb_stall_cnt = r_sb_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_sb.sv
// tb_fwd_hazard_sb: directed checks of forwarding, load-use,
// scoreboard, capacity/error, saturation and flush behaviour.
module tb_fwd_hazard_sb;

    localparam int W  = 5;
    localparam int NS = 3;
    localparam int CW = 4;

    logic          CLK;
    logic          rst_n;
    logic          id_valid;
    logic [NS*W-1:0] id_rs;
    logic [NS-1:0] id_rs_use;
    logic [NS-1:0] id_rs_fp;
    logic          ID_EX_valid;
    logic          ID_EX_Mem_Rd;
    logic          ID_EX_Reg_Wr;
    logic          ID_EX_rd_fp;
    logic [W-1:0]  ID_EX_rd;
    logic [NS*W-1:0] ID_EX_rs;
    logic [NS-1:0] ID_EX_rs_fp;
    logic          EX_MEM_Reg_Wr;
    logic          EX_MEM_rd_fp;
    logic [W-1:0]  EX_MEM_rd;
    logic          MEM_WB_Reg_Wr;
    logic          MEM_WB_rd_fp;
    logic [W-1:0]  MEM_WB_rd;
    logic          long_issue;
    logic          long_issue_fp;
    logic [W-1:0]  long_issue_rd;
    logic          long_wb_valid;
    logic          long_wb_fp;
    logic [W-1:0]  long_wb_rd;
    logic          flush;
    logic [2*NS-1:0] Forward;
    logic          id_stall;
    logic [1:0]    stall_cause;
    logic          long_ready;
    logic          sb_err;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] sb_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fwd_hazard_sb #(
        .WIDTH_SOURCE(W), .NUM_SRC(NS), .MAX_LONG(4), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_use(id_rs_use), .id_rs_fp(id_rs_fp),
        .ID_EX_valid(ID_EX_valid), .ID_EX_Mem_Rd(ID_EX_Mem_Rd),
        .ID_EX_Reg_Wr(ID_EX_Reg_Wr), .ID_EX_rd_fp(ID_EX_rd_fp),
        .ID_EX_rd(ID_EX_rd), .ID_EX_rs(ID_EX_rs),
        .ID_EX_rs_fp(ID_EX_rs_fp),
        .EX_MEM_Reg_Wr(EX_MEM_Reg_Wr), .EX_MEM_rd_fp(EX_MEM_rd_fp),
        .EX_MEM_rd(EX_MEM_rd),
        .MEM_WB_Reg_Wr(MEM_WB_Reg_Wr), .MEM_WB_rd_fp(MEM_WB_rd_fp),
        .MEM_WB_rd(MEM_WB_rd),
        .long_issue(long_issue), .long_issue_fp(long_issue_fp),
        .long_issue_rd(long_issue_rd),
        .long_wb_valid(long_wb_valid), .long_wb_fp(long_wb_fp),
        .long_wb_rd(long_wb_rd),
        .flush(flush),
        .Forward(Forward), .id_stall(id_stall),
        .stall_cause(stall_cause), .long_ready(long_ready),
        .sb_err(sb_err), .stall_cnt(stall_cnt),
        .sb_stall_cnt(sb_stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_rs = '0; id_rs_use = '0; id_rs_fp = '0;
        ID_EX_valid = 0; ID_EX_Mem_Rd = 0; ID_EX_Reg_Wr = 0;
        ID_EX_rd_fp = 0; ID_EX_rd = '0; ID_EX_rs = '0;
        ID_EX_rs_fp = '0;
        EX_MEM_Reg_Wr = 0; EX_MEM_rd_fp = 0; EX_MEM_rd = '0;
        MEM_WB_Reg_Wr = 0; MEM_WB_rd_fp = 0; MEM_WB_rd = '0;
        long_issue = 0; long_issue_fp = 0; long_issue_rd = '0;
        long_wb_valid = 0; long_wb_fp = 0; long_wb_rd = '0;
        flush = 0;
    endtask

    task automatic set_load_use();
        ID_EX_valid = 1; ID_EX_Mem_Rd = 1; ID_EX_Reg_Wr = 1;
        ID_EX_rd_fp = 0; ID_EX_rd = 5'd7;
        id_valid = 1; id_rs = {5'd0, 5'd7, 5'd0};
        id_rs_use = 3'b010; id_rs_fp = 3'b000;
    endtask

    initial begin
        clr();
        rst_n = 0;
        #1;
        chk("rst_long_ready", long_ready, 1);
        chk("rst_id_stall", id_stall, 0);
        chk("rst_forward", Forward, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        tick();
        tick();
        rst_n = 1;

        // Forward priority (combinational only, no clock edge)
        EX_MEM_Reg_Wr = 1; EX_MEM_rd = 5'd5;
        MEM_WB_Reg_Wr = 1; MEM_WB_rd = 5'd5;
        long_wb_valid = 1; long_wb_rd = 5'd5;
        ID_EX_rs = {5'd0, 5'd0, 5'd5};
        #1 chk("fwd_exmem", Forward, 6'b000010);
        EX_MEM_Reg_Wr = 0;
        #1 chk("fwd_memwb", Forward, 6'b000001);
        MEM_WB_Reg_Wr = 0;
        #1 chk("fwd_longwb", Forward, 6'b000011);
        long_wb_valid = 0;
        #1 chk("fwd_none", Forward, 6'b000000);

        // Class and x0 rules
        EX_MEM_Reg_Wr = 1; EX_MEM_rd = 5'd0; EX_MEM_rd_fp = 0;
        ID_EX_rs = '0; ID_EX_rs_fp = '0;
        #1 chk("fwd_x0", Forward[1:0], 2'b00);
        EX_MEM_rd_fp = 1; ID_EX_rs_fp = 3'b001;
        #1 chk("fwd_f0", Forward[1:0], 2'b10);
        EX_MEM_rd = 5'd3; ID_EX_rs = {5'd0, 5'd0, 5'd3};
        ID_EX_rs_fp = 3'b000;
        #1 chk("fwd_class", Forward[1:0], 2'b00);
        clr();
        tick();
        chk("idle_sb_err", sb_err, 0);

        // Load-use: one stall cycle, then EX/MEM forward
        set_load_use();
        #1;
        chk("lu_stall", id_stall, 1);
        chk("lu_cause", stall_cause, 2'b01);
        tick();
        clr();
        EX_MEM_Reg_Wr = 1; EX_MEM_rd = 5'd7;
        ID_EX_rs = {5'd0, 5'd7, 5'd0};
        #1;
        chk("lu_after_stall", id_stall, 0);
        chk("lu_fwd_rs2", Forward[3:2], 2'b10);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_sb_cnt", sb_stall_cnt, 0);
        clr();

        // Scoreboard stall on f9 until after its writeback
        long_issue = 1; long_issue_fp = 1; long_issue_rd = 5'd9;
        tick();
        long_issue = 0;
        id_valid = 1; id_rs = {5'd0, 5'd0, 5'd9};
        id_rs_use = 3'b001; id_rs_fp = 3'b001;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin
                long_wb_valid = 1; long_wb_fp = 1; long_wb_rd = 5'd9;
            end
            #1;
            chk($sformatf("sb_cause_c%0d", c), stall_cause, 2'b10);
            tick();
        end
        long_wb_valid = 0;
        #1;
        chk("sb_drop_cause", stall_cause, 2'b00);
        chk("sb_drop_stall", id_stall, 0);
        chk("sb_stall_cnt", sb_stall_cnt, 7);
        chk("sb_total_cnt", stall_cnt, 8);
        chk("sb_err_clean", sb_err, 0);
        id_valid = 0;

        // Same-cycle issue and writeback of f9: bit stays set
        long_issue = 1; long_issue_fp = 1; long_issue_rd = 5'd9;
        tick();
        long_wb_valid = 1; long_wb_fp = 1; long_wb_rd = 5'd9;
        tick();
        long_issue = 0; long_wb_valid = 0;
        id_valid = 1;
        #1;
        chk("same_cycle_bit", stall_cause, 2'b10);
        chk("same_cycle_ready", long_ready, 1);
        id_valid = 0;
        long_wb_valid = 1;
        tick();
        long_wb_valid = 0;
        chk("same_cycle_err", sb_err, 0);

        // Flush masks the stall but keeps the bitmap
        long_issue = 1;
        tick();
        long_issue = 0;
        id_valid = 1; flush = 1;
        #1;
        chk("flush_stall", id_stall, 0);
        chk("flush_cause", stall_cause, 2'b00);
        tick();
        flush = 0;
        #1;
        chk("flush_kept_bit", stall_cause, 2'b10);
        chk("flush_no_count", stall_cnt, 8);
        id_valid = 0;
        long_wb_valid = 1;
        tick();
        long_wb_valid = 0;

        // Capacity: four outstanding, fifth is rejected
        clr();
        for (int k = 1; k <= 4; k++) begin
            long_issue = 1; long_issue_rd = 5'(k);
            tick();
        end
        long_issue = 0;
        chk("cap_not_ready", long_ready, 0);
        chk("cap_no_err", sb_err, 0);
        long_issue = 1; long_issue_rd = 5'd5;
        tick();
        long_issue = 0;
        chk("cap_err", sb_err, 1);
        chk("cap_still_full", long_ready, 0);
        id_valid = 1; id_rs = {5'd0, 5'd0, 5'd5}; id_rs_use = 3'b001;
        #1 chk("cap_ignored_bit", stall_cause, 2'b00);
        id_rs = {5'd0, 5'd0, 5'd1};
        #1 chk("cap_x1_pending", stall_cause, 2'b10);
        id_valid = 0;

        // Asynchronous reset mid-operation
        #2 rst_n = 0;
        #1;
        chk("arst_ready", long_ready, 1);
        chk("arst_err", sb_err, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_sb_cnt", sb_stall_cnt, 0);
        tick();
        rst_n = 1;
        id_valid = 1;
        #1 chk("arst_bitmap", stall_cause, 2'b00);
        id_valid = 0;

        // Writeback of an unowned register
        long_wb_valid = 1; long_wb_fp = 0; long_wb_rd = 5'd12;
        tick();
        long_wb_valid = 0;
        chk("wb_unset_err", sb_err, 1);
        chk("wb_unset_ready", long_ready, 1);
        rst_n = 0;
        tick();
        rst_n = 1;

        // Counter saturation at all-ones
        clr();
        set_load_use();
        for (int k = 0; k < 20; k++) tick();
        chk("sat_stall_cnt", stall_cnt, 15);
        chk("sat_sb_cnt", sb_stall_cnt, 0);
        chk("sat_still_stall", id_stall, 1);
        clr();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
